// File: rtl/clock_display_scan_if.sv
// Signal bundle between the clock core (master) and the six-digit display scan driver (slave).
interface clock_display_scan_if;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hr;
  logic       i_blink_en;
  logic [1:0] i_blink_sel;
  logic [5:0] o_digit_en;
  logic [6:0] o_seg;
  logic       o_dp;

  modport master (
    output i_sec, i_min, i_hr, i_blink_en, i_blink_sel,
    input  o_digit_en, o_seg, o_dp
  );

  modport slave (
    input  i_sec, i_min, i_hr, i_blink_en, i_blink_sel,
    output o_digit_en, o_seg, o_dp
  );
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit 7-segment scan driver: per-frame time snapshot, decimal decode, per-field blink.
// Outputs are registered one cycle behind the digit index so enable, segments and dp switch together.
module clock_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 500000
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  clock_display_scan_if.slave dsp
);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         dig_q, dig_d;
  logic [5:0]         sec_q, sec_d;
  logic [5:0]         min_q, min_d;
  logic [4:0]         hr_q, hr_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [5:0]         digit_en_q, digit_en_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic       scan_tc;
  logic       frame_wrap;
  logic [1:0] dig_field;
  logic       blank;
  logic [6:0] field_val [3];
  logic [6:0] dig_code  [6];

  assign field_val[0] = {1'b0, sec_q};
  assign field_val[1] = {1'b0, min_q};
  assign field_val[2] = {2'b00, hr_q};

  // Each field feeds two adjacent digits: ones at the even index, tens at the odd one.
  for (genvar gi = 0; gi < 3; gi++) begin : g_field
    localparam logic [6:0] FIELD_MAX = (gi == 2) ? 7'd23 : 7'd59;
    logic       bad;
    logic [3:0] tens;
    logic [3:0] ones;
    assign bad  = field_val[gi] > FIELD_MAX;
    assign tens = 4'(field_val[gi] / 7'd10);
    assign ones = 4'(field_val[gi] % 7'd10);
    assign dig_code[2*gi]   = bad ? 7'h40 : seg7(ones);
    assign dig_code[2*gi+1] = bad ? 7'h40 : seg7(tens);
  end

  assign scan_tc    = (scan_cnt_q == SCAN_LAST);
  assign frame_wrap = scan_tc && (dig_q == 3'd5);
  assign dig_field  = dig_q[2:1] + 2'd1;
  // Select code 0 can never match dig_field (1..3), so "none" never blanks.
  assign blank      = dsp.i_blink_en && blink_ph_q && (dsp.i_blink_sel == dig_field);

  always_comb begin
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
    dig_d       = dig_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;

    if (scan_tc) begin
      dig_d = frame_wrap ? 3'd0 : dig_q + 3'd1;
    end
    if (frame_wrap) begin
      sec_d = dsp.i_sec;
      min_d = dsp.i_min;
      hr_d  = dsp.i_hr;
    end
    if (dsp.i_blink_en) begin
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_ph_d  = (blink_cnt_q == BLINK_LAST) ? ~blink_ph_q : blink_ph_q;
    end

    digit_en_d = 6'b000001 << dig_q;
    dp_d       = (dig_q == 3'd2) || (dig_q == 3'd4);
    seg_d      = blank ? 7'h00 : dig_code[dig_q];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scan_cnt_q  <= '0;
      dig_q       <= 3'd0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hr_q        <= 5'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      digit_en_q  <= 6'b000001;
      seg_q       <= 7'h3F;
      dp_q        <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      dig_q       <= dig_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      digit_en_q  <= digit_en_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign dsp.o_digit_en = digit_en_q;
  assign dsp.o_seg      = seg_q;
  assign dsp.o_dp       = dp_q;
endmodule
